// File: rtl/wtg_pc_unit_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// wtg_pc_unit_if
// Bundles the decode-side request signals and the fetch-side PC outputs of
// wtg_pc_unit. The redirect op encodings are provided here with include
// guards, so an external Core.vh that defines them first takes precedence.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`ifndef WTG_OP_BIT
`define WTG_OP_BIT 4
`endif
`ifndef WTG_OP_SEQ
`define WTG_OP_SEQ  0
`endif
`ifndef WTG_OP_J32
`define WTG_OP_J32  1
`endif
`ifndef WTG_OP_J26
`define WTG_OP_J26  2
`endif
`ifndef WTG_OP_BEQ
`define WTG_OP_BEQ  3
`endif
`ifndef WTG_OP_BNE
`define WTG_OP_BNE  4
`endif
`ifndef WTG_OP_BLEZ
`define WTG_OP_BLEZ 5
`endif
`ifndef WTG_OP_BGTZ
`define WTG_OP_BGTZ 6
`endif
`ifndef WTG_OP_BLTZ
`define WTG_OP_BLTZ 7
`endif
`ifndef WTG_OP_BGEZ
`define WTG_OP_BGEZ 8
`endif

interface wtg_pc_unit_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) ();
  // Requests from decode / register read
  logic                   en;
  logic [`WTG_OP_BIT-1:0] op;
  logic [31:0]            off32;
  logic [25:0]            imm26;
  logic [31:0]            data_x;
  logic [31:0]            data_y;
  logic                   halt;
  // PC and status towards fetch
  logic [PC_W-1:0]        pc;
  logic [PC_W-1:0]        pc_4;
  logic                   branched;
  logic                   pending;
  logic                   slot_err;
  logic                   halted;
  logic [CNT_W-1:0]       taken_cnt;
  logic [CNT_W-1:0]       jump_cnt;

  modport master (
    output en, op, off32, imm26, data_x, data_y, halt,
    input  pc, pc_4, branched, pending, slot_err, halted, taken_cnt, jump_cnt
  );

  modport slave (
    input  en, op, off32, imm26, data_x, data_y, halt,
    output pc, pc_4, branched, pending, slot_err, halted, taken_cnt, jump_cnt
  );
endinterface

`default_nettype wire

// File: rtl/wtg_pc_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// wtg_pc_unit
// Registered program counter with J32/J26/conditional-branch redirects, an
// optional MIPS delay slot and a sticky halt.
// Optional macro WTG_STAT_EN: adds saturating taken-branch / jump counters;
// when undefined both counter outputs are tied to zero.
// The interface instance must carry the same PC_W / CNT_W as this module.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module wtg_pc_unit #(
  parameter int              PC_W       = 32,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter int              DELAY_SLOT = 0,
  parameter int              CNT_W      = 32
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  wtg_pc_unit_if.slave   bus
);

  localparam logic [`WTG_OP_BIT-1:0] OP_J32  = `WTG_OP_BIT'(`WTG_OP_J32);
  localparam logic [`WTG_OP_BIT-1:0] OP_J26  = `WTG_OP_BIT'(`WTG_OP_J26);
  localparam logic [`WTG_OP_BIT-1:0] OP_BEQ  = `WTG_OP_BIT'(`WTG_OP_BEQ);
  localparam logic [`WTG_OP_BIT-1:0] OP_BNE  = `WTG_OP_BIT'(`WTG_OP_BNE);
  localparam logic [`WTG_OP_BIT-1:0] OP_BLEZ = `WTG_OP_BIT'(`WTG_OP_BLEZ);
  localparam logic [`WTG_OP_BIT-1:0] OP_BGTZ = `WTG_OP_BIT'(`WTG_OP_BGTZ);
  localparam logic [`WTG_OP_BIT-1:0] OP_BLTZ = `WTG_OP_BIT'(`WTG_OP_BLTZ);
  localparam logic [`WTG_OP_BIT-1:0] OP_BGEZ = `WTG_OP_BIT'(`WTG_OP_BGEZ);

  // RUN: normal sequencing; SLOT: delay-slot instruction is executing
  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_SLOT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] tgt_q, tgt_d;
  logic            branched_q, branched_d;
  logic            slot_err_q, slot_err_d;
  logic            halted_q, halted_d;

  logic [PC_W-1:0] pc_4_w;
  logic [PC_W-1:0] j32_tgt;
  logic [PC_W-1:0] j26_tgt;
  logic [PC_W-1:0] br_tgt;
  logic [PC_W-1:0] target;
  logic            is_jump;
  logic            is_branch;
  logic            br_cond;
  logic            br_taken;
  logic            redirect;
  logic            count_br;
  logic            count_jmp;

  // Only slices of the operand buses are used for narrow PCs
  logic            unused_bits;
  assign unused_bits = ^{bus.data_x, bus.off32};

  assign pc_4_w  = pc_q + PC_W'(4);
  assign j32_tgt = {bus.data_x[PC_W-1:2], 2'b00};
  assign br_tgt  = pc_4_w + {bus.off32[PC_W-3:0], 2'b00};

  // J26 keeps the region bits above bit 27, which only exist for PC_W > 28
  generate
    if (PC_W > 28) begin : g_j26_region
      assign j26_tgt = {pc_4_w[PC_W-1:28], bus.imm26, 2'b00};
    end else begin : g_j26_flat
      assign j26_tgt = {bus.imm26, 2'b00};
    end
  endgenerate

  // Decode the op into jump/branch class, branch condition and target
  always_comb begin
    is_jump   = 1'b0;
    is_branch = 1'b0;
    br_cond   = 1'b0;
    target    = pc_4_w;
    case (bus.op)
      OP_J32:  begin is_jump = 1'b1; target = j32_tgt; end
      OP_J26:  begin is_jump = 1'b1; target = j26_tgt; end
      OP_BEQ:  begin is_branch = 1'b1; target = br_tgt; br_cond = (bus.data_x == bus.data_y); end
      OP_BNE:  begin is_branch = 1'b1; target = br_tgt; br_cond = (bus.data_x != bus.data_y); end
      OP_BLEZ: begin is_branch = 1'b1; target = br_tgt; br_cond = ($signed(bus.data_x) <= 32'sd0); end
      OP_BGTZ: begin is_branch = 1'b1; target = br_tgt; br_cond = ($signed(bus.data_x) >  32'sd0); end
      OP_BLTZ: begin is_branch = 1'b1; target = br_tgt; br_cond = ($signed(bus.data_x) <  32'sd0); end
      OP_BGEZ: begin is_branch = 1'b1; target = br_tgt; br_cond = ($signed(bus.data_x) >= 32'sd0); end
      default: ;
    endcase
  end

  assign br_taken = is_branch & br_cond;
  assign redirect = is_jump | br_taken;

  // Next-state logic: halt beats any redirect; the slot ignores redirect ops
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tgt_d      = tgt_q;
    branched_d = branched_q;
    slot_err_d = slot_err_q;
    halted_d   = halted_q;
    count_br   = 1'b0;
    count_jmp  = 1'b0;
    if (bus.en && !halted_q) begin
      branched_d = 1'b0;
      if (bus.halt) begin
        halted_d = 1'b1;
      end else begin
        case (state_q)
          ST_RUN: begin
            if (redirect) begin
              branched_d = br_taken;
              count_br   = br_taken;
              count_jmp  = is_jump;
              if (DELAY_SLOT != 0) begin
                tgt_d   = target;
                pc_d    = pc_4_w;
                state_d = ST_SLOT;
              end else begin
                pc_d = target;
              end
            end else begin
              pc_d = pc_4_w;
            end
          end
          ST_SLOT: begin
            pc_d    = tgt_q;
            state_d = ST_RUN;
            if (redirect) begin
              slot_err_d = 1'b1;
            end
          end
          default: state_d = ST_RUN;
        endcase
      end
    end
  end

  // Architectural state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      tgt_q      <= '0;
      branched_q <= 1'b0;
      slot_err_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tgt_q      <= tgt_d;
      branched_q <= branched_d;
      slot_err_q <= slot_err_d;
      halted_q   <= halted_d;
    end
  end

`ifdef WTG_STAT_EN
  logic [CNT_W-1:0] taken_cnt_q;
  logic [CNT_W-1:0] jump_cnt_q;

  // Saturating statistics counters, advanced only by RUN-state redirects
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt_q <= '0;
      jump_cnt_q  <= '0;
    end else begin
      if (count_br && (taken_cnt_q != '1)) begin
        taken_cnt_q <= taken_cnt_q + CNT_W'(1);
      end
      if (count_jmp && (jump_cnt_q != '1)) begin
        jump_cnt_q <= jump_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.taken_cnt = taken_cnt_q;
  assign bus.jump_cnt  = jump_cnt_q;
`else
  logic unused_cnt;
  assign unused_cnt    = count_br ^ count_jmp;
  assign bus.taken_cnt = '0;
  assign bus.jump_cnt  = '0;
`endif

  assign bus.pc       = pc_q;
  assign bus.pc_4     = pc_4_w;
  assign bus.branched = branched_q;
  assign bus.pending  = (DELAY_SLOT != 0) && (state_q == ST_SLOT);
  assign bus.slot_err = slot_err_q;
  assign bus.halted   = halted_q;

endmodule

`default_nettype wire

// File: tb/tb_wtg_pc_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_wtg_pc_unit
// Two instances share clock and reset: index 0 without delay slot, index 1
// with delay slot. Both have RESET_PC=0x7C and CNT_W=2. A reference model
// tracks each instance and is compared on every falling edge; directed
// literal checks pin the model to hand-computed values.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_wtg_pc_unit;

  localparam logic [31:0] RPC = 32'h0000_007C;
  localparam int          CW  = 2;

  localparam logic [3:0] OP_SEQ  = 4'(`WTG_OP_SEQ);
  localparam logic [3:0] OP_J32  = 4'(`WTG_OP_J32);
  localparam logic [3:0] OP_J26  = 4'(`WTG_OP_J26);
  localparam logic [3:0] OP_BEQ  = 4'(`WTG_OP_BEQ);
  localparam logic [3:0] OP_BNE  = 4'(`WTG_OP_BNE);
  localparam logic [3:0] OP_BLEZ = 4'(`WTG_OP_BLEZ);
  localparam logic [3:0] OP_BGTZ = 4'(`WTG_OP_BGTZ);
  localparam logic [3:0] OP_BLTZ = 4'(`WTG_OP_BLTZ);
  localparam logic [3:0] OP_BGEZ = 4'(`WTG_OP_BGEZ);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        pend;
    logic        br;
    logic        serr;
    logic        halt;
    logic [31:0] tc;
    logic [31:0] jc;
  } mstate_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic        s_en   [2];
  logic [3:0]  s_op   [2];
  logic [31:0] s_off  [2];
  logic [25:0] s_imm  [2];
  logic [31:0] s_x    [2];
  logic [31:0] s_y    [2];
  logic        s_halt [2];

  logic [31:0]   d_pc  [2];
  logic [31:0]   d_pc4 [2];
  logic          d_br  [2];
  logic          d_pend[2];
  logic          d_serr[2];
  logic          d_halt[2];
  logic [CW-1:0] d_tc  [2];
  logic [CW-1:0] d_jc  [2];

  mstate_t m [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wtg_pc_unit_if #(.PC_W(32), .CNT_W(CW)) bus0 ();
  wtg_pc_unit_if #(.PC_W(32), .CNT_W(CW)) bus1 ();

  assign bus0.en = s_en[0];  assign bus0.op = s_op[0];  assign bus0.off32 = s_off[0];
  assign bus0.imm26 = s_imm[0]; assign bus0.data_x = s_x[0]; assign bus0.data_y = s_y[0];
  assign bus0.halt = s_halt[0];
  assign bus1.en = s_en[1];  assign bus1.op = s_op[1];  assign bus1.off32 = s_off[1];
  assign bus1.imm26 = s_imm[1]; assign bus1.data_x = s_x[1]; assign bus1.data_y = s_y[1];
  assign bus1.halt = s_halt[1];

  assign d_pc[0] = bus0.pc;   assign d_pc4[0] = bus0.pc_4;  assign d_br[0] = bus0.branched;
  assign d_pend[0] = bus0.pending; assign d_serr[0] = bus0.slot_err; assign d_halt[0] = bus0.halted;
  assign d_tc[0] = bus0.taken_cnt; assign d_jc[0] = bus0.jump_cnt;
  assign d_pc[1] = bus1.pc;   assign d_pc4[1] = bus1.pc_4;  assign d_br[1] = bus1.branched;
  assign d_pend[1] = bus1.pending; assign d_serr[1] = bus1.slot_err; assign d_halt[1] = bus1.halted;
  assign d_tc[1] = bus1.taken_cnt; assign d_jc[1] = bus1.jump_cnt;

  wtg_pc_unit #(.PC_W(32), .RESET_PC(RPC), .DELAY_SLOT(0), .CNT_W(CW)) u_ds0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave)
  );
  wtg_pc_unit #(.PC_W(32), .RESET_PC(RPC), .DELAY_SLOT(1), .CNT_W(CW)) u_ds1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
  );

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v < 32'd3) ? v + 32'd1 : 32'd3;
  endfunction

  // One enabled update of the architectural rules
  function automatic mstate_t model_next(input mstate_t s, input bit ds, input logic en,
                                         input logic [3:0] op, input logic [31:0] off,
                                         input logic [25:0] imm, input logic [31:0] x,
                                         input logic [31:0] y, input logic halt);
    mstate_t     n    = s;
    logic [31:0] seq  = s.pc + 32'd4;
    logic [31:0] dst  = seq + off * 32'd4;
    bit          jmp  = 1'b0;
    bit          take = 1'b0;
    if (s.halt || !en) return s;
    n.br = 1'b0;
    if (halt) begin
      n.halt = 1'b1;
      return n;
    end
    if (op == OP_J32)  begin jmp = 1'b1; dst = x & ~32'd3; end
    if (op == OP_J26)  begin jmp = 1'b1; dst = (seq & 32'hF000_0000) | (32'(imm) * 32'd4); end
    if (op == OP_BEQ)  take = (x == y);
    if (op == OP_BNE)  take = (x != y);
    if (op == OP_BLEZ) take = ($signed(x) <= 0);
    if (op == OP_BGTZ) take = ($signed(x) > 0);
    if (op == OP_BLTZ) take = ($signed(x) < 0);
    if (op == OP_BGEZ) take = ($signed(x) >= 0);
    if (s.pend) begin
      n.pc   = s.tgt;
      n.pend = 1'b0;
      if (jmp || take) n.serr = 1'b1;
      return n;
    end
    if (jmp || take) begin
      n.br = take;
      if (take) n.tc = sat_inc(s.tc);
      if (jmp)  n.jc = sat_inc(s.jc);
      if (ds) begin
        n.tgt  = dst;
        n.pc   = seq;
        n.pend = 1'b1;
      end else begin
        n.pc = dst;
      end
    end else begin
      n.pc = seq;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) m[i] <= '{pc: RPC, default: '0};
    end else begin
      for (int i = 0; i < 2; i++)
        m[i] <= model_next(m[i], (i == 1), s_en[i], s_op[i], s_off[i], s_imm[i],
                           s_x[i], s_y[i], s_halt[i]);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("pc[%0d]", i),       d_pc[i],   m[i].pc);
      chk($sformatf("pc_4[%0d]", i),     d_pc4[i],  m[i].pc + 32'd4);
      chk($sformatf("branched[%0d]", i), 32'(d_br[i]),   32'(m[i].br));
      chk($sformatf("pending[%0d]", i),  32'(d_pend[i]), 32'(m[i].pend));
      chk($sformatf("slot_err[%0d]", i), 32'(d_serr[i]), 32'(m[i].serr));
      chk($sformatf("halted[%0d]", i),   32'(d_halt[i]), 32'(m[i].halt));
`ifdef WTG_STAT_EN
      chk($sformatf("taken_cnt[%0d]", i), 32'(d_tc[i]), m[i].tc);
      chk($sformatf("jump_cnt[%0d]", i),  32'(d_jc[i]), m[i].jc);
`else
      chk($sformatf("taken_cnt[%0d]", i), 32'(d_tc[i]), 32'd0);
      chk($sformatf("jump_cnt[%0d]", i),  32'(d_jc[i]), 32'd0);
`endif
    end
  end

  task automatic drive(input int i, input logic [3:0] op, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] off,
                       input logic [25:0] imm, input logic h);
    s_en[i] = 1'b1; s_op[i] = op; s_x[i] = x; s_y[i] = y;
    s_off[i] = off; s_imm[i] = imm; s_halt[i] = h;
    s_en[1-i] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    s_en[0] = 1'b0; s_en[1] = 1'b0; s_halt[0] = 1'b0; s_halt[1] = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      s_en[i] = 1'b0; s_op[i] = OP_SEQ; s_off[i] = '0; s_imm[i] = '0;
      s_x[i] = '0; s_y[i] = '0; s_halt[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk("rst_pc0", d_pc[0], 32'h7C);
    chk("rst_pc1", d_pc[1], 32'h7C);
    chk("rst_halted0", 32'(d_halt[0]), 32'd0);
    chk("rst_pending1", 32'(d_pend[1]), 32'd0);
    rst_n = 1'b1;

    // Sequential flow, including an unlisted op encoding
    drive(0, OP_SEQ, 0, 0, 0, 0, 0); tick(); chk("seq1", d_pc[0], 32'h80);
    drive(0, 4'hF, 0, 0, 0, 0, 0);   tick(); chk("seq2", d_pc[0], 32'h84);
    drive(0, OP_SEQ, 0, 0, 0, 0, 0); tick(); chk("seq3", d_pc[0], 32'h88);
    chk("seq_br", 32'(d_br[0]), 32'd0);
    chk("seq_pc4", d_pc4[0], 32'h8C);

    // BEQ taken, then sequential clears branched
    do_reset();
    drive(0, OP_BEQ, 5, 5, 32'h10, 0, 0); tick();
    chk("beq_t_pc", d_pc[0], 32'hC0); chk("beq_t_br", 32'(d_br[0]), 32'd1);
    drive(0, OP_SEQ, 0, 0, 0, 0, 0); tick();
    chk("beq_t_pc2", d_pc[0], 32'hC4); chk("beq_t_br2", 32'(d_br[0]), 32'd0);
    do_reset();
    drive(0, OP_BEQ, 5, 6, 32'h10, 0, 0); tick();
    chk("beq_nt_pc", d_pc[0], 32'h80); chk("beq_nt_br", 32'(d_br[0]), 32'd0);

    // Jumps and the remaining branch conditions
    drive(0, OP_J32, 32'h1000_0000, 0, 0, 0, 0); tick(); chk("j32a", d_pc[0], 32'h1000_0000);
    drive(0, OP_J26, 0, 0, 0, 26'h010_0000, 0);  tick(); chk("j26", d_pc[0], 32'h1040_0000);
    chk("j26_br", 32'(d_br[0]), 32'd0);
    drive(0, OP_J32, 32'h0000_1003, 0, 0, 0, 0); tick(); chk("j32b", d_pc[0], 32'h1000);
    drive(0, OP_BLEZ, 0, 0, 32'hFFFF_FFFF, 0, 0); tick(); chk("blez_t", d_pc[0], 32'h1000);
    chk("blez_br", 32'(d_br[0]), 32'd1);
    drive(0, OP_BGTZ, 0, 0, 32'h10, 0, 0); tick(); chk("bgtz_nt", d_pc[0], 32'h1004);
    drive(0, OP_BGTZ, 1, 0, 0, 0, 0); tick(); chk("bgtz_t", d_pc[0], 32'h1008);
    drive(0, OP_BLTZ, 32'h8000_0000, 0, 2, 0, 0); tick(); chk("bltz_t", d_pc[0], 32'h1014);
    drive(0, OP_J32, 0, 0, 0, 0, 0); s_en[0] = 1'b0; tick();
    chk("en0_pc", d_pc[0], 32'h1014); chk("en0_br", 32'(d_br[0]), 32'd1);
    drive(0, OP_BGEZ, 32'hFFFF_FFFF, 0, 5, 0, 0); tick(); chk("bgez_nt", d_pc[0], 32'h1018);
    drive(0, OP_BNE, 3, 3, 5, 0, 0); tick(); chk("bne_nt", d_pc[0], 32'h101C);
    drive(0, OP_J32, 32'hFFFF_FFFC, 0, 0, 0, 0); tick(); chk("wrap_pc4", d_pc4[0], 32'h0);
    drive(0, OP_SEQ, 0, 0, 0, 0, 0); tick(); chk("wrap_pc", d_pc[0], 32'h0);

    // Delay slot: BLTZ then an ignored BNE in the slot
    do_reset();
    drive(1, OP_BLTZ, 32'hFFFF_FFFF, 0, 4, 0, 0); tick();
    chk("ds_pc1", d_pc[1], 32'h80); chk("ds_pend1", 32'(d_pend[1]), 32'd1);
    chk("ds_br1", 32'(d_br[1]), 32'd1);
    drive(1, OP_BNE, 1, 2, 32'h40, 0, 0); tick();
    chk("ds_pc2", d_pc[1], 32'h90); chk("ds_pend2", 32'(d_pend[1]), 32'd0);
    chk("ds_serr", 32'(d_serr[1]), 32'd1);
    drive(1, OP_SEQ, 0, 0, 0, 0, 0); tick(); chk("ds_pc3", d_pc[1], 32'h94);

    // Halt beats a taken BGEZ; en then ignored; reset clears
    do_reset();
    chk("serr_clr", 32'(d_serr[1]), 32'd0);
    drive(0, OP_J32, 32'h200, 0, 0, 0, 0); tick(); chk("h_pc0", d_pc[0], 32'h200);
    drive(0, OP_BGEZ, 0, 0, 8, 0, 1); tick();
    chk("h_pc1", d_pc[0], 32'h200); chk("h_halt", 32'(d_halt[0]), 32'd1);
    chk("h_br", 32'(d_br[0]), 32'd0);
    drive(0, OP_SEQ, 0, 0, 0, 0, 0); tick(); tick(); chk("h_pc2", d_pc[0], 32'h200);
    do_reset();
    chk("h_rst_pc", d_pc[0], 32'h7C); chk("h_rst_halt", 32'(d_halt[0]), 32'd0);

    // Halt while in the slot keeps pending
    drive(1, OP_BEQ, 0, 0, 1, 0, 0); tick(); chk("hs_pend0", 32'(d_pend[1]), 32'd1);
    drive(1, OP_SEQ, 0, 0, 0, 0, 1); tick(); tick();
    chk("hs_pc", d_pc[1], 32'h80); chk("hs_pend", 32'(d_pend[1]), 32'd1);
    chk("hs_halt", 32'(d_halt[1]), 32'd1);

    // Counter saturation and asynchronous reset in the slot
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1, OP_BNE, 1, 2, 0, 0, 0); tick();
      drive(1, OP_SEQ, 0, 0, 0, 0, 0); tick();
    end
    drive(1, OP_J32, 32'h40, 0, 0, 0, 0); tick();
    drive(1, OP_SEQ, 0, 0, 0, 0, 0); tick(); chk("cnt_pc", d_pc[1], 32'h40);
`ifdef WTG_STAT_EN
    chk("taken_sat", 32'(d_tc[1]), 32'd3); chk("jump_one", 32'(d_jc[1]), 32'd1);
`else
    chk("taken_off", 32'(d_tc[1]), 32'd0); chk("jump_off", 32'(d_jc[1]), 32'd0);
`endif
    drive(1, OP_BNE, 1, 2, 0, 0, 0); tick(); chk("mid_pend", 32'(d_pend[1]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_pend", 32'(d_pend[1]), 32'd0); chk("mid_rst_pc", d_pc[1], 32'h7C);
    chk("mid_rst_tc", 32'(d_tc[1]), 32'd0); chk("mid_rst_jc", 32'(d_jc[1]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, OP_SEQ, 0, 0, 0, 0, 0); tick(); chk("post_rst_pc", d_pc[1], 32'h80);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wtg_pc_unit.md
Name: wtg_pc_unit

Overview:
- Registered program-counter unit and the sequential successor to the combinational where-to-go logic.
- Holds the architectural PC and evaluates J32/J26/BEQ/BNE/BLEZ/BGTZ/BLTZ/BGEZ redirects each enabled cycle.
- Optionally models a MIPS branch delay slot, and latches a halt.
- Sits between decode/register-read (op, operands) and instruction fetch (pc).

Parameters:
- PC_W, 32, PC width. Legal range 28..32. J26 keeps bits [PC_W-1:28] of pc+4.
- RESET_PC, 0, PC value loaded on reset. Must be word aligned.
- DELAY_SLOT, 0, 0 = redirect takes effect next update; 1 = one delay-slot instruction executes first.
- CNT_W, 32, width of the statistics counters (optional feature).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  advance enable; PC and state update only when high.
- op  in  `WTG_OP_BIT  redirect op from Core.vh; any non-listed encoding = sequential (pc+4).
- off32  in  32  sign-extended branch word offset.
- imm26  in  26  jump index.
- data_x  in  32  rs operand; also the J32 target.
- data_y  in  32  rt operand.
- halt  in  1  stop request.
- pc  out  PC_W  current PC.
- pc_4  out  PC_W  pc+4, combinational from pc, wraps modulo 2^PC_W.
- branched  out  1  registered pulse: a conditional branch was taken on the last enabled update.
- pending  out  1  a delay-slot redirect target is latched (DELAY_SLOT=1 only, else 0).
- slot_err  out  1  sticky: a redirect op was presented in a delay slot.
- halted  out  1  sticky halt flag.
- taken_cnt  out  CNT_W  taken conditional branches (optional).
- jump_cnt  out  CNT_W  J32/J26 executed (optional).

Behaviour:
- Reset (async, rst_n=0) values: pc=RESET_PC; branched=0; pending=0; slot_err=0; halted=0; counters=0; target register=0.
- Targets:
  - J32 = data_x[PC_W-1:0] with bits [1:0] forced to 0.
  - J26 = {pc_4[PC_W-1:28], imm26, 2'b00}.
  - Branch = pc_4 + (off32<<2), truncated to PC_W.
- Branch conditions:
  - BEQ: x==y. BNE: x!=y.
  - BLEZ: signed x<=0. BGTZ: signed x>0.
  - BLTZ: signed x<0. BGEZ: signed x>=0.
- Redirect = J32, J26, or a taken branch.
- State machine, two states RUN and SLOT.
  - RUN, en=1, halted=0:
    - If halt=1: set halted, pc holds, no redirect is evaluated (halt beats branch in the same cycle).
    - Else if redirect and DELAY_SLOT=0: pc <= target.
    - Else if redirect and DELAY_SLOT=1: latch target, pc <= pc_4, pending <= 1, go to SLOT.
    - Else: pc <= pc_4.
  - SLOT, en=1, halted=0:
    - pc <= latched target, pending <= 0, go to RUN.
    - A redirect op presented here is ignored and sets slot_err.
    - halt=1 here: halted set, pc holds, remains in SLOT with pending=1 until reset.
- en=0: all state holds. branched keeps its value (it reflects the last enabled update).
- Once halted=1: only reset clears it. en is ignored.
- branched <= 1 on an enabled update where a conditional branch was taken, including when the target is only latched in SLOT mode. J32/J26 do not set it.
- A reset asserted mid-SLOT discards the latched target. pc returns to RESET_PC.
- Latency: one clock from en-sampled inputs to the pc change. DELAY_SLOT=1 adds one further enabled update.

Optional Feature:
- Macro WTG_STAT_EN.
- Defined: taken_cnt increments on each enabled update with a taken conditional branch; jump_cnt increments on each enabled update with J32/J26. Both count in RUN state only, not halted. Both saturate at 2^CNT_W-1; no wrap.
- Undefined: both outputs are constant 0 and no counter flops are inferred.

Test Plan:
- Sequential, RESET_PC=0x7C, DELAY_SLOT=0: release reset, op=non-redirect, en=1 for 3 cycles -> pc 0x7C, 0x80, 0x84, 0x88; branched=0.
- BEQ at pc=0x7C, off32=0x10, x=y=5 -> next pc=0xC0, branched=1 for one update. Repeat with y=6 -> pc=0x80, branched=0.
- J26 at pc=0x1000_0000, imm26=0x010_0000 -> pc=0x1040_0000, branched=0. J32 data_x=0x0000_1003 -> pc=0x1000.
- DELAY_SLOT=1, BLTZ at pc=0x7C, x=-1, off32=4 -> pc=0x80 with pending=1, then pc=0x90 with pending=0. A BNE presented in the slot sets slot_err=1 and pc is still 0x90.
- BGEZ taken (x=0) with halt=1 in the same cycle at pc=0x200 -> pc stays 0x200, halted=1; further en cycles leave pc unchanged. rst_n pulse low -> pc=RESET_PC, halted=0.
- WTG_STAT_EN defined, CNT_W=2: five taken BNE plus one J32 -> taken_cnt=3 (saturated), jump_cnt=1. Async reset mid-SLOT -> counters 0, pending 0.
